// File: rtl/rr_arbiter_8_if.sv
// Handshake bundle between the requester bank and the round-robin arbiter.
interface rr_arbiter_8_if;
  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  logic [N-1:0]     req;
  logic             rel;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             busy;
  logic             timeout;

  // Requester side drives requests and the release strobe.
  modport master (
    output req,
    output rel,
    input  gnt,
    input  gnt_idx,
    input  busy,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  rel,
    output gnt,
    output gnt_idx,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter; every owner change passes through IDLE.
// Optional hold-time limit with forced release when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          nrst,
  rr_arbiter_8_if.slave bus
);
  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pick_c;
  logic             found_c;
  logic             expire_c;
  logic             release_c;

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("rr_arbiter_8: MAX_HOLD must lie in 2..256");
  end

  // First requester at or after ptr, wrapping 7 -> 0.
  always_comb begin
    found_c = 1'b0;
    pick_c  = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!found_c && bus.req[ptr_q + IDX_W'(i)]) begin
        found_c = 1'b1;
        pick_c  = ptr_q + IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    release_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = GRANT;
          idx_d   = pick_c;
        end
      end
      GRANT: begin
        release_c = bus.rel || !bus.req[idx_q] || expire_c;
        if (release_c) begin
          state_d = IDLE;
          ptr_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign expire_c = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));

  // Counter runs only while granted; timeout flags expiry not masked by rel or owner drop.
  always_comb begin
    cnt_d     = '0;
    timeout_d = 1'b0;
    if (state_q == GRANT) begin
      cnt_d     = cnt_q + CNT_W'(1);
      timeout_d = expire_c && !bus.rel && bus.req[idx_q];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire_c    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Grant decoded from registered state only, so it cannot glitch with req.
  assign bus.busy    = (state_q == GRANT);
  assign bus.gnt_idx = idx_q;
  assign bus.gnt     = (state_q == GRANT) ? (N'(1) << idx_q) : '0;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 (timeout checks follow RR_ARB_TIMEOUT_EN).
module tb_rr_arbiter_8;
  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fail;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then stable for sampling and driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst    = 1'b0;
    bus.req = 8'hFF;
    bus.rel = 1'b0;
    step();
    step();
    n_checks++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL reset_gnt: got %h want 00", bus.gnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.gnt_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", bus.gnt_idx); end
    n_checks++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    nrst = 1'b1;
    step();
    n_checks++; if (bus.gnt !== 8'h01) begin n_fail++; $display("FAIL reset_first_gnt: got %h want 01", bus.gnt); end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_gnt;
    for (int i = 1; i <= 8; i++) begin
      exp_gnt = 8'h01 << 3'(i % 8);
      bus.rel = 1'b1;
      step();
      n_checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rotation_idle[%0d]: got gnt %h busy %b want 00 0", i, bus.gnt, bus.busy); end
      bus.rel = 1'b0;
      step();
      n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL rotation_gnt[%0d]: got %h want %h", i, bus.gnt, exp_gnt); end
    end
  endtask

  task automatic test_pointer_wrap();
    // Owner 0 releases (ptr=1); only requester 6 asks.
    bus.rel = 1'b1;
    step();
    bus.rel = 1'b0;
    bus.req = 8'h40;
    step();
    n_checks++; if (bus.gnt !== 8'h40) begin n_fail++; $display("FAIL wrap_setup_gnt6: got %h want 40", bus.gnt); end
    bus.req = 8'h41;
    bus.rel = 1'b1;
    step();
    n_checks++; if (bus.gnt_idx !== 3'd6 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL wrap_idx_hold: got idx %0d busy %b want 6 0", bus.gnt_idx, bus.busy); end
    bus.rel = 1'b0;
    step();
    n_checks++; if (bus.gnt !== 8'h01) begin n_fail++; $display("FAIL wrap_7_to_0: got %h want 01", bus.gnt); end
    bus.rel = 1'b1;
    step();
    bus.rel = 1'b0;
    step();
    n_checks++; if (bus.gnt !== 8'h40 || bus.gnt_idx !== 3'd6) begin n_fail++; $display("FAIL wrap_from_0: got %h idx %0d want 40 6", bus.gnt, bus.gnt_idx); end
  endtask

  task automatic test_owner_drop();
    // Owner 6 releases (ptr=7); search 7,0,1,2,3 lands on 3.
    bus.req = 8'h08;
    bus.rel = 1'b1;
    step();
    bus.rel = 1'b0;
    step();
    n_checks++; if (bus.gnt !== 8'h08) begin n_fail++; $display("FAIL drop_gnt3: got %h want 08", bus.gnt); end
    bus.req = 8'h20;
    step();
    n_checks++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL drop_release: got %h want 00", bus.gnt); end
    step();
    n_checks++; if (bus.gnt !== 8'h20) begin n_fail++; $display("FAIL drop_regrant5: got %h want 20", bus.gnt); end
    bus.req = 8'h00;
    step();
    bus.rel = 1'b1;
    step();
    n_checks++; if (bus.busy !== 1'b0 || bus.gnt !== 8'h00 || bus.gnt_idx !== 3'd5) begin n_fail++; $display("FAIL idle_rel: got busy %b gnt %h idx %0d want 0 00 5", bus.busy, bus.gnt, bus.gnt_idx); end
    bus.rel = 1'b0;
    bus.req = 8'h21;
    step();
    n_checks++; if (bus.gnt !== 8'h01) begin n_fail++; $display("FAIL idle_rel_ptr: got %h want 01", bus.gnt); end
    bus.req = 8'h00;
    step();
  endtask

  task automatic test_timeout();
    // ptr=1 here; requester 2 is the only one asking.
    bus.req = 8'h04;
    step();
`ifdef RR_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (bus.gnt !== 8'h04 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL hold_cycle[%0d]: got gnt %h to %b want 04 0", c, bus.gnt, bus.timeout); end
      step();
    end
    n_checks++; if (bus.gnt !== 8'h00 || bus.timeout !== 1'b1) begin n_fail++; $display("FAIL forced_release: got gnt %h to %b want 00 1", bus.gnt, bus.timeout); end
    step();
    n_checks++; if (bus.gnt !== 8'h04 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_regrant: got gnt %h to %b want 04 0", bus.gnt, bus.timeout); end
    step();
    step();
    step();
    bus.rel = 1'b1;
    step();
    n_checks++; if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL rel_at_expiry: got gnt %h to %b want 00 0", bus.gnt, bus.timeout); end
`else
    for (int c = 0; c < 20; c++) step();
    n_checks++; if (bus.gnt !== 8'h04 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL no_timeout_hold: got gnt %h to %b want 04 0", bus.gnt, bus.timeout); end
    bus.rel = 1'b1;
    step();
    n_checks++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL no_timeout_rel: got %h want 00", bus.gnt); end
`endif
    bus.rel = 1'b0;
    bus.req = 8'h00;
    step();
  endtask

  task automatic test_mid_grant_reset();
    // ptr=3 after owner 2 left; search 3,4,5 lands on 5.
    bus.req = 8'h20;
    step();
    n_checks++; if (bus.gnt !== 8'h20) begin n_fail++; $display("FAIL mid_reset_gnt5: got %h want 20", bus.gnt); end
    #2;
    nrst = 1'b0;
    #1;
    n_checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_drop: got gnt %h busy %b want 00 0", bus.gnt, bus.busy); end
    bus.req = 8'h30;
    nrst    = 1'b1;
    step();
    n_checks++; if (bus.gnt !== 8'h10) begin n_fail++; $display("FAIL post_reset_gnt4: got %h want 10", bus.gnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_rotation();
    test_pointer_wrap();
    test_owner_drop();
    test_timeout();
    test_mid_grant_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one downstream resource among eight requesters. It registers an encoded owner index and drives a one-hot grant vector decoded from that index. It holds the grant until the owner releases it, drops its request, or (optionally) exceeds a hold limit. The block sits between the requester bank and the shared resource's select logic, and its `gnt` output feeds the resource's one-hot select.

## Interface
- `MAX_HOLD`, 16: maximum grant duration in cycles when the timeout feature is compiled in. Legal range is 2..256.
- `clk` input 1: single clock; all state changes on the rising edge.
- `nrst` input 1: asynchronous, active-low reset.
- `req` input 8: request vector; bit k is requester k, level-sensitive.
- `rel` input 1: release strobe from the current owner; ignored when `busy`=0.
- `gnt` output 8: one-hot grant, equal to `8'b1 << gnt_idx` when `busy`=1, otherwise 0.
- `gnt_idx` output 3: encoded current (or last) owner.
- `busy` output 1: high while a grant is held (state GRANT).
- `timeout` output 1: one-cycle pulse marking a forced release.

## Operation
- Two states, IDLE and GRANT. Internal 3-bit priority pointer `ptr`.
- **IDLE:**
  - If `req` is 0, stay in IDLE.
  - Otherwise select the first set bit of `req` searching `ptr`, `ptr+1`, … wrapping 7→0. Load it into `gnt_idx` and go to GRANT.
- **GRANT:** owner is `gnt_idx`. Release condition at an edge:
  - `rel`=1, or
  - `req[gnt_idx]`=0, or
  - the hold counter expires (feature only).
- **On release:**
  - state → IDLE; `ptr` ← `gnt_idx`+1 mod 8 (7 wraps to 0).
  - `gnt_idx` keeps its value, for visibility.
- Requests from non-owners during GRANT have no effect. Any owner change goes through IDLE.
- `gnt` is decoded combinationally from registered `gnt_idx` and `busy`. It is glitch-free relative to `clk`, with no dependence on `req` in the same cycle.
- **Reset values:** state IDLE, `ptr`=0, `gnt_idx`=0, `gnt`=0, `busy`=0, `timeout`=0, hold counter 0.
- **Reset during GRANT:** `gnt` and `busy` drop immediately (asynchronously); `ptr` returns to 0.

## Timing
- **Grant latency:** `req` sampled nonzero at edge t in IDLE → `gnt`/`busy` high in the cycle after edge t.
- **Release latency:** release condition sampled at edge t → `gnt`=0 from edge t.
- **Turnaround:** at least one full cycle with `gnt`=0 between consecutive grants. Maximum grant rate is one grant every 2 cycles plus hold time.
- **Hold counter (feature only):**
  - Cleared on entry to GRANT; increments each GRANT cycle.
  - At an edge in GRANT with counter = `MAX_HOLD`-1 and no other release condition: forced release, and `timeout`=1 for exactly the following cycle.
  - A grant therefore lasts at most `MAX_HOLD` cycles.
- **Simultaneous events:** `rel` (or owner drop) at the same edge as expiry is a normal release and `timeout` stays 0.
- **Fairness:** under saturating requests, each requester is served within 8 grants.

## Configuration
- Macro `RR_ARB_TIMEOUT_EN`.
- **Defined:** hold counter (width ceil(log2(`MAX_HOLD`))) and forced release are present as described.
- **Undefined:**
  - No counter is instantiated and `timeout` is tied to 0.
  - A grant persists until `rel` or owner drop, indefinitely.
  - `MAX_HOLD` is ignored.

## Test plan
- **Reset:** hold `nrst`=0 with `req`=8'hFF → `gnt`=0, `busy`=0, `gnt_idx`=0, `timeout`=0. Release reset → first `gnt`=8'h01 one cycle later.
- **Rotation:** `req`=8'hFF constant, owner pulses `rel` one cycle after each grant → grant sequence 01,02,04,…,80,01, separated by one idle cycle each.
- **Pointer wrap:** last owner 6, then `req`=8'h41 → grant to 0 (`ptr`=7 wraps). Repeat with last owner 0 and `req`=8'h41 → grant to 6.
- **Owner drop:** grant to 3; drop `req[3]` while `req[5]`=1 → `gnt`=0 the next cycle, then `gnt`=8'h20. `rel` pulsed while `busy`=0 → no effect.
- **Timeout (macro defined, `MAX_HOLD`=4):** `req`=8'h04 held, no `rel` → `gnt`=8'h04 for exactly 4 cycles, `timeout`=1 for one cycle, then regrant to 2 after one idle cycle. `rel` at the expiry edge → `timeout` stays 0.
- **Mid-grant reset:** assert `nrst`=0 asynchronously during a grant to 5 → `gnt` drops without a clock edge. After release with `req`=8'h30 → grant to 4.
